// File: rtl/lsu_mac_if.sv
// LSU-side request/response and byte-wide memory bus of the load/store
// memory access controller, bundled so both sides share one declaration.
interface lsu_mac_if #(
   parameter int ADDR_W = 16
);
   // LSU request / response
   logic              req;
   logic              we;
   logic              wide;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic [15:0]       rdata;
   // byte memory bus
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_rdata;
   logic              mem_rdy;

   // Environment side: issues requests and plays the memory.
   modport master (
      output req, we, wide, addr, wdata, mem_rdata, mem_rdy,
      input  busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
   );

   // Controller side.
   modport slave (
      input  req, we, wide, addr, wdata, mem_rdata, mem_rdy,
      output busy, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/lsu_mac.sv
// Load/store memory access controller: turns one LSU access into one or two
// byte transfers on the 8-bit memory bus, assembles little-endian read data,
// and aborts any byte phase that waits TIMEOUT cycles for mem_rdy.
module lsu_mac #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input logic       clk,
   input logic       rst,
   lsu_mac_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic              wide_q, wide_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              eflag_q, eflag_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;

   // This wait cycle is the last one allowed for the current byte phase.
   logic tmo;
   assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State, latched request and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         wide_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         eflag_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         wide_q      <= wide_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         eflag_q     <= eflag_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   // Next state: advance on mem_rdy, bail out to FIN on wait-state timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.req) state_d = LO;
         LO: begin
            if (bus.mem_rdy) state_d = wide_q ? HI : FIN;
            else if (tmo)    state_d = FIN;
         end
         HI:   if (bus.mem_rdy || tmo) state_d = FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and next values of the registered outputs.
   always_comb begin
      we_d        = we_q;
      wide_d      = wide_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      eflag_d     = eflag_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            eflag_d = 1'b0;
            if (bus.req) begin
               we_d        = bus.we;
               wide_d      = bus.wide;
               addr_d      = bus.addr;
               wdata_d     = bus.wdata;
               mem_addr_d  = bus.addr;
               mem_wdata_d = bus.wdata[7:0];
               mem_rd_d    = !bus.we;
               mem_wr_d    = bus.we;
            end
         end
         LO: begin
            if (bus.mem_rdy) begin
               cnt_d = '0;
               if (!we_q) rdata_d[7:0] = bus.mem_rdata;
               if (wide_q) begin
                  // second byte goes to addr+1, wrapping at the top of memory
                  mem_addr_d  = addr_q + ADDR_W'(1);
                  mem_wdata_d = wdata_q[15:8];
               end else begin
                  mem_rd_d = 1'b0;
                  mem_wr_d = 1'b0;
                  if (!we_q) rdata_d[15:8] = 8'h00;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (tmo) begin
                  mem_rd_d = 1'b0;
                  mem_wr_d = 1'b0;
                  eflag_d  = 1'b1;
               end
            end
         end
         HI: begin
            if (bus.mem_rdy) begin
               if (!we_q) rdata_d[15:8] = bus.mem_rdata;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (tmo) begin
                  mem_rd_d = 1'b0;
                  mem_wr_d = 1'b0;
                  eflag_d  = 1'b1;
               end
            end
         end
         FIN: begin
            cnt_d   = '0;
            eflag_d = 1'b0;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
      err_d  = (state_d == FIN) && eflag_d;
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
endmodule

// File: doc/lsu_mac.md
Name: lsu_mac

Overview:
- Load/store memory access controller; sits directly downstream of the LSU effective-address unit.
- Takes the assembled 16-bit effective address plus an access request, and runs one or two byte transfers on the 8-bit memory bus with a ready handshake.
- Returns read data, 8- or 16-bit little-endian, to the LSU with a one-cycle completion pulse.
- Bounds every byte transfer with a wait-state timeout.

Parameters:
- ADDR_W, 16, effective/memory address width.
- TIMEOUT, 15, max cycles a byte phase waits for mem_rdy before aborting (>=1).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  start access; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; latched with req.
- wide  in  1  1 = 16-bit access (two bytes), 0 = 8-bit; latched with req.
- addr  in  ADDR_W  effective address from the address unit; latched with req.
- wdata  in  16  store data; low byte to addr, high byte to addr+1; latched with req.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done when the access timed out.
- rdata  out  16  load result.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  8  byte to memory.
- mem_rd  out  1  read strobe, held until mem_rdy.
- mem_wr  out  1  write strobe, held until mem_rdy.
- mem_rdata  in  8  byte from memory, valid when mem_rdy=1.
- mem_rdy  in  1  memory accepts/returns the byte this cycle.

Behaviour:
- All outputs registered.
- Reset values: busy=0, done=0, err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0; state=IDLE; timeout counter=0.
- Reset mid-access aborts immediately: strobes drop the next cycle, and no done or err is produced.
- States: IDLE, LO, HI, FIN.
- IDLE, req=1:
  - Latch we, wide, addr, wdata; go to LO.
  - Next cycle: mem_addr=addr, mem_wdata=wdata[7:0], mem_rd=!we, mem_wr=we, busy=1.
- IDLE, req=0: stay in IDLE, strobes low.
- LO, mem_rdy=1:
  - Load: rdata[7:0] <= mem_rdata.
  - If wide: go to HI with mem_addr=addr+1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000), mem_wdata=wdata[15:8], same strobe polarity.
  - Else: drop strobes, go to FIN; a narrow load also clears rdata[15:8] to 0.
- HI, mem_rdy=1: load captures rdata[15:8] <= mem_rdata; drop strobes; go to FIN.
- LO/HI, mem_rdy=0:
  - Hold mem_addr, mem_wdata and strobes stable; increment the counter.
  - Counter clears on every entry to LO or HI.
  - When the counter reaches TIMEOUT with no rdy: drop strobes, go to FIN, set the error flag. rdata keeps whatever bytes were already captured.
- FIN:
  - done=1 for exactly one cycle; err=1 in the same cycle if the error flag is set; busy=1.
  - Then IDLE; flag cleared.
- req in any state other than IDLE is ignored, including FIN. No queuing.
- Stores never modify rdata; rdata holds its value between accesses.
- Latency with zero wait states (req sampled at cycle 0):
  - Narrow: strobe in cycle 1, done in cycle 2.
  - Wide: strobes in cycles 1-2, done in cycle 3.
  - Each wait cycle adds 1.
- mem_rd and mem_wr are never both 1.

Test Plan:
- Narrow load, addr=0x1234, mem_rdy tied 1, mem_rdata=0xA5 -> cycle1 mem_addr=0x1234, mem_rd=1; cycle2 done=1, err=0, rdata=0x00A5; busy low in cycle3.
- Wide store, addr=0x2000, wdata=0xBEEF, rdy=1 -> mem_wr=1 with 0x2000/0xEF, then 0x2001/0xBE; done in cycle3; rdata unchanged.
- Wide load at addr=0xFFFF with 2 wait states per byte, bytes 0x34 then 0x12 -> second mem_addr=0x0000, strobes held stable while waiting, rdata=0x1234, done at cycle 7.
- mem_rdy held 0 with TIMEOUT=15 -> strobe drops after 15 wait cycles, done=1 and err=1 together, busy returns 0; a subsequent req starts normally.
- rst asserted during HI of a wide load -> next cycle all outputs 0, state IDLE, no done; req pulses during busy/FIN are ignored (exactly one done per accepted req).
